rr_mux_arb: RTL and testbench

- Parametrised successor to the fixed 5-input, 8-bit select mux.
- Merges N valid/ready source channels of W-bit data into one registered output stream.
- The select is generated internally by a round-robin arbiter, not supplied by the user.
- Sits between multiple producers (e.g. cache/uncached request queues) and one shared bus port in the CPU datapath.

---
 rtl/rr_mux_arb_pkg.sv | 23 ++
 rtl/rr_mux_arb_pick.sv | 54 +++++
 rtl/rr_mux_arb.sv | 155 +++++++++++++++
 tb/tb_rr_mux_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg: shared constants and helpers for the round-robin mux arbiter.
//   sel_w()     - channel-index width for N channels (at least 1 bit)
//   rst_ptr()   - pointer value after reset (N-1, so channel 0 wins first)
//   params_ok() - legal-range check for N and W, used at elaboration time
package rr_mux_arb_pkg;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 16;
    localparam int unsigned W_MIN = 1;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned rst_ptr(input int unsigned n);
        return n - 1;
    endfunction

    function automatic bit params_ok(input int unsigned n, input int unsigned w);
        return (n >= N_MIN) && (n <= N_MAX) && (w >= W_MIN);
    endfunction

endpackage

// File: rtl/rr_mux_arb_pick.sv
// rr_pick: purely combinational round-robin picker.
//   req     [N]     - request vector
//   ptr     [SEL_W] - index of the last granted channel; search starts at ptr+1
//   gnt     [N]     - one-hot grant, or zero when nothing requests
//   gnt_idx [SEL_W] - index of the granted channel (0 when gnt is zero)
// The request vector is doubled and shifted so the search start lands at bit 0;
// the winning offset is then added back to the start modulo N (not 2^SEL_W).
module rr_pick
    import rr_mux_arb_pkg::*;
#(
    parameter int unsigned N     = 5,
    parameter int unsigned SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   N_VAL = (SEL_W + 1)'(N);

    logic [SEL_W-1:0] start;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;
    logic             found;
    logic [SEL_W:0]   sum;

    always_comb begin
        start = (ptr >= LAST) ? '0 : ptr + 1'b1;
        dbl   = {req, req};
        rot   = N'(dbl >> start);
        found = 1'b0;
        off   = '0;
        // Descending scan so the lowest set offset (closest to start) wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = SEL_W'(k);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= N_VAL) begin
            sum = sum - N_VAL;
        end
        gnt_idx = found ? sum[SEL_W-1:0] : '0;
        gnt     = '0;
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: merges N valid/ready channels of W-bit data into one registered
// output stream; the channel select comes from an internal round-robin arbiter.
//   clk, resetn           - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready [N] - per-channel handshake
//   in_data [N*W]         - channel i at bits [i*W +: W]
//   in_last [N]           - end-of-packet flag, only used with packet lock
//   out_valid/out_ready   - output handshake; out_data/out_sel are registered
// Optional feature macro: RR_MUX_ARB_PKT_LOCK_EN. When defined, a channel that
// transfers a non-last beat holds the grant until its last beat, and the
// round-robin pointer only advances on last beats.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned W = 8,
    localparam int unsigned SEL_W = sel_w(N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel
);

    if (!params_ok(N, W)) begin : g_bad_param
        $error("rr_mux_arb: N must be 2..16 and W at least 1");
    end

    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(rst_ptr(N));

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     pick_gnt, gnt;
    logic [SEL_W-1:0] pick_idx, gnt_idx;
    logic             load, xfer;
    logic [W-1:0]     mux_data;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    assign load     = !out_valid_q || out_ready;
    assign in_ready = gnt & {N{load}};
    assign xfer     = |(in_valid & in_ready);

    // AND-OR mux: gnt is one-hot or zero, so at most one term contributes.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[i*W +: W] & {W{gnt[i]}});
        end
    end

`ifdef RR_MUX_ARB_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic             last_beat;

    // While locked the grant stays on the locked channel even if it idles.
    always_comb begin
        if (lock_q) begin
            gnt             = '0;
            gnt[lock_idx_q] = 1'b1;
            gnt_idx         = lock_idx_q;
        end else begin
            gnt     = pick_gnt;
            gnt_idx = pick_idx;
        end
    end

    assign last_beat = in_last[gnt_idx];

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        if (xfer) begin
            lock_d     = !last_beat;
            lock_idx_d = gnt_idx;
            if (last_beat) begin
                ptr_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = ^in_last;

    assign gnt     = pick_gnt;
    assign gnt_idx = pick_idx;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = gnt_idx;
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = mux_data;
                out_sel_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= PTR_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed self-checking bench for rr_mux_arb: a default 5x8 instance and a
// 3x32 instance sharing clock and reset.
module tb_rr_mux_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  in_valid, in_ready, in_last;
    logic [39:0] in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;

    logic [2:0]  v3, r3, l3;
    logic [95:0] d3;
    logic        ov3, or3;
    logic [31:0] od3;
    logic [1:0]  os3;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    rr_mux_arb #(.N(5), .W(8)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    rr_mux_arb #(.N(3), .W(32)) u_dut3 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (v3),
        .in_ready  (r3),
        .in_data   (d3),
        .in_last   (l3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (od3),
        .out_sel   (os3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data_10;
        for (int i = 0; i < 5; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    endtask

    task automatic test_reset;
        resetn = 1'b0; in_valid = '0; in_last = '1; in_data = '0; out_ready = 1'b0;
        v3 = '0; l3 = '1; d3 = '0; or3 = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passes++;
        checks++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h want 00", out_data); else passes++;
        checks++; if (out_sel !== 3'd0) $display("FAIL rst_sel: got %0d want 0", out_sel); else passes++;
        checks++; if (in_ready !== 5'b0) $display("FAIL rst_ready: got %b want 00000", in_ready); else passes++;
        #11 resetn = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        in_valid = 5'h1F; set_data_10(); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 5'b00001) $display("FAIL rr_first_ready: got %b want 00001", in_ready); else passes++;
        for (int k = 0; k < 10; k++) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(k % 5) || out_data !== 8'(8'h10 + k % 5))
                $display("FAIL rr_beat[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         k, out_valid, out_sel, out_data, k % 5, 8'(8'h10 + k % 5));
            else passes++;
            checks++;
            if (in_ready !== 5'(1 << ((k + 1) % 5)))
                $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, 5'(1 << ((k + 1) % 5)));
            else passes++;
        end
        in_valid = '0;
        tick;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h14 || out_sel !== 3'd4)
            $display("FAIL rr_drain: got v=%b data=%h sel=%0d want v=0 data=14 sel=4",
                     out_valid, out_data, out_sel);
        else passes++;
    endtask

    // Pointer is 4 here: search wraps to channel 0 first.
    task automatic test_wrap;
        in_valid = 5'b10010; in_data = '0; in_data[15:8] = 8'h21; in_data[39:32] = 8'h24;
        #1;
        checks++; if (in_ready !== 5'b00010) $display("FAIL wrap_ready0: got %b want 00010", in_ready); else passes++;
        tick;
        checks++;
        if (out_sel !== 3'd1 || out_data !== 8'h21)
            $display("FAIL wrap_beat0: got sel=%0d data=%h want sel=1 data=21", out_sel, out_data);
        else passes++;
        checks++; if (in_ready !== 5'b10000) $display("FAIL wrap_ready1: got %b want 10000", in_ready); else passes++;
        tick;
        checks++;
        if (out_sel !== 3'd4 || out_data !== 8'h24)
            $display("FAIL wrap_beat1: got sel=%0d data=%h want sel=4 data=24", out_sel, out_data);
        else passes++;
        in_valid = '0;
        tick;
    endtask

    task automatic test_stall;
        in_valid = 5'b01000; in_data = '0; in_data[31:24] = 8'hA5; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 5'b01000) $display("FAIL stall_ready_pre: got %b want 01000", in_ready); else passes++;
        tick;
        in_data[31:24] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 3'd3 || in_ready !== 5'b0)
                $display("FAIL stall_hold[%0d]: got v=%b data=%h sel=%0d rdy=%b want v=1 data=a5 sel=3 rdy=00000",
                         k, out_valid, out_data, out_sel, in_ready);
            else passes++;
            if (k < 2) tick;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 5'b01000) $display("FAIL stall_ready_post: got %b want 01000", in_ready); else passes++;
        tick;
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A)
            $display("FAIL stall_release: got v=%b data=%h want v=1 data=5a", out_valid, out_data);
        else passes++;
        tick;
        checks++; if (out_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_async_reset;
        in_valid = 5'h1F; set_data_10(); out_ready = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h14)
            $display("FAIL arst_pre: got v=%b data=%h want v=1 data=14", out_valid, out_data);
        else passes++;
        #3 resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0)
            $display("FAIL arst_now: got v=%b data=%h sel=%0d want v=0 data=00 sel=0",
                     out_valid, out_data, out_sel);
        else passes++;
        #2 resetn = 1'b1;
        #1;
        checks++; if (in_ready !== 5'b00001) $display("FAIL arst_prio: got %b want 00001", in_ready); else passes++;
        out_ready = 1'b1;
        tick;
        checks++;
        if (out_sel !== 3'd0 || out_data !== 8'h10)
            $display("FAIL arst_first: got sel=%0d data=%h want sel=0 data=10", out_sel, out_data);
        else passes++;
        in_valid = '0;
        tick;
    endtask

    // N=3: ch2 always valid, ch0 beats arrive at cycles 1, 4 and 5.
    task automatic test_fairness_n3;
        bit          arrive [8]  = '{0, 1, 0, 0, 1, 1, 0, 0};
        logic [1:0]  exp_sel [8] = '{2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        logic [31:0] exp_dat [8] = '{32'hC2C2_0000, 32'hA0A0_0000, 32'hC2C2_0001, 32'hC2C2_0002,
                                     32'hA0A0_0001, 32'hC2C2_0003, 32'hA0A0_0002, 32'hC2C2_0004};
        int pend = 0, m = 0, n = 0, cur_wait = 0;
        bit hs0, hs2;
        or3 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (arrive[c]) pend++;
            v3 = {1'b1, 1'b0, pend > 0};
            d3 = '0;
            d3[95:64] = 32'hC2C2_0000 + 32'(n);
            d3[31:0]  = 32'hA0A0_0000 + 32'(m);
            #3;
            hs0 = v3[0] && r3[0];
            hs2 = v3[2] && r3[2];
            tick;
            checks++;
            if (ov3 !== 1'b1 || os3 !== exp_sel[c] || od3 !== exp_dat[c])
                $display("FAIL n3_beat[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         c, ov3, os3, od3, exp_sel[c], exp_dat[c]);
            else passes++;
            if (hs0) begin
                checks++;
                if (cur_wait > 2) $display("FAIL n3_ch0_wait: got %0d want <=2", cur_wait);
                else passes++;
                pend--; m++; cur_wait = 0;
            end else if (v3[0]) begin
                cur_wait++;
            end
            if (hs2) n++;
        end
        v3 = '0;
        checks++;
        if (m !== 3 || n !== 5) $display("FAIL n3_counts: got ch0=%0d ch2=%0d want ch0=3 ch2=5", m, n);
        else passes++;
        tick;
        checks++; if (ov3 !== 1'b0) $display("FAIL n3_drain: got %b want 0", ov3); else passes++;
    endtask

    // ch1 packet against continuously valid ch0/ch2, starting from ptr=0.
    task automatic test_pkt;
        out_ready = 1'b1;
        in_valid = 5'b00001; in_last = '1; in_data = 40'h00_00_42_00_40;
        tick;
        in_valid = 5'b00111; in_last = 5'b11101; in_data[15:8] = 8'h31;
        #1;
        checks++; if (in_ready !== 5'b00010) $display("FAIL pkt_ready0: got %b want 00010", in_ready); else passes++;
        tick;
        checks++;
        if (out_sel !== 3'd1 || out_data !== 8'h31)
            $display("FAIL pkt_beat1: got sel=%0d data=%h want sel=1 data=31", out_sel, out_data);
        else passes++;
        in_valid = 5'b00101;
        #1;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
        checks++; if (in_ready !== 5'b00010) $display("FAIL pkt_lock_hold: got %b want 00010", in_ready); else passes++;
        tick;
        checks++; if (out_valid !== 1'b0) $display("FAIL pkt_bubble: got %b want 0", out_valid); else passes++;
        in_valid = 5'b00111; in_data[15:8] = 8'h32;
        tick;
        checks++;
        if (out_sel !== 3'd1 || out_data !== 8'h32)
            $display("FAIL pkt_beat2: got sel=%0d data=%h want sel=1 data=32", out_sel, out_data);
        else passes++;
        in_data[15:8] = 8'h33; in_last = 5'b11111;
        tick;
        checks++;
        if (out_sel !== 3'd1 || out_data !== 8'h33)
            $display("FAIL pkt_beat3: got sel=%0d data=%h want sel=1 data=33", out_sel, out_data);
        else passes++;
        in_valid = 5'b00101;
        tick;
        checks++;
        if (out_sel !== 3'd2 || out_data !== 8'h42)
            $display("FAIL pkt_after2: got sel=%0d data=%h want sel=2 data=42", out_sel, out_data);
        else passes++;
        in_valid = 5'b00001;
        tick;
        checks++;
        if (out_sel !== 3'd0 || out_data !== 8'h40)
            $display("FAIL pkt_after0: got sel=%0d data=%h want sel=0 data=40", out_sel, out_data);
        else passes++;
`else
        checks++; if (in_ready !== 5'b00100) $display("FAIL nolock_ready: got %b want 00100", in_ready); else passes++;
        tick;
        checks++;
        if (out_sel !== 3'd2 || out_data !== 8'h42)
            $display("FAIL nolock_beat: got sel=%0d data=%h want sel=2 data=42", out_sel, out_data);
        else passes++;
`endif
        in_valid = '0;
        tick;
        checks++; if (out_valid !== 1'b0) $display("FAIL pkt_drain: got %b want 0", out_valid); else passes++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_async_reset();
        test_fairness_n3();
        test_pkt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
